// File: rtl/cpu_defs.sv
// Shared CPU definitions: datapath widths, writeback value-select codes,
// architectural register indices and the forwarding result record.
package cpu_defs;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;

  typedef enum logic [1:0] {
    WB_SEL_ALU  = 2'b00,
    WB_SEL_MEM  = 2'b01,
    WB_SEL_LINK = 2'b10,
    WB_SEL_IMM  = 2'b11
  } wb_sel_e;

  localparam logic [ADDR_W-1:0] REG_ZERO = 4'd0;
  localparam logic [ADDR_W-1:0] REG_IH   = 4'd13;
  localparam logic [ADDR_W-1:0] REG_T    = 4'd14;
  localparam logic [ADDR_W-1:0] REG_SP   = 4'd15;

  typedef struct packed {
    logic              hit;
    logic [DATA_W-1:0] data;
  } fwd_result_t;

  function automatic logic [DATA_W-1:0] wb_mux(input wb_sel_e           sel,
                                               input logic [DATA_W-1:0] alu,
                                               input logic [DATA_W-1:0] mem,
                                               input logic [DATA_W-1:0] link,
                                               input logic [DATA_W-1:0] imm);
    logic [DATA_W-1:0] v;
    v = alu;
    case (sel)
      WB_SEL_MEM:  v = mem;
      WB_SEL_LINK: v = link;
      WB_SEL_IMM:  v = imm;
      default:     v = alu;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/wb_queue.sv
// Circular FIFO of pending register writes {addr, data}. The slot view is
// ordered oldest (slot 0, the head) to youngest for the forwarding search.
module wb_queue
  import cpu_defs::*;
#(
  parameter int  DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic [ADDR_W-1:0]       push_addr,
  input  logic [DATA_W-1:0]       push_data,
  input  logic                    pop,
  output logic [CNT_W-1:0]        count,
  output logic [DEPTH*ADDR_W-1:0] slot_addr,
  output logic [DEPTH*DATA_W-1:0] slot_data,
  output logic [DEPTH-1:0]        slot_valid
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [ADDR_W-1:0] mem_addr [DEPTH];
  logic [DATA_W-1:0] mem_data [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [PTR_W-1:0] slot_idx(input logic [PTR_W-1:0] base, input int i);
    int s;
    s = int'(base) + i;
    if (s >= DEPTH) s = s - DEPTH;
    return PTR_W'(s);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // NOTE: storage has no reset; an entry is only observed while count says it is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[wr_ptr] <= push_addr;
      mem_data[wr_ptr] <= push_data;
    end
  end

  always_comb begin
    slot_addr  = '0;
    slot_data  = '0;
    slot_valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slot_addr[i*ADDR_W +: ADDR_W] = mem_addr[slot_idx(rd_ptr, i)];
      slot_data[i*DATA_W +: DATA_W] = mem_data[slot_idx(rd_ptr, i)];
      slot_valid[i]                 = (i < int'(count));
    end
  end

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: selects the retiring value, queues it, and replays each
// queued result as a SETUP/STROBE register-file write; forwards pending values.
module writeback_stage
  import cpu_defs::*;
#(
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_dest,
  input  logic [1:0]        wb_sel,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] mem_data,
  input  logic [DATA_W-1:0] pc_link,
  input  logic [DATA_W-1:0] imm,
  output logic              wb_stall,
  output logic              rf_write,
  output logic [ADDR_W-1:0] rf_address,
  output logic [DATA_W-1:0] rf_data_in,
  input  logic [ADDR_W-1:0] fwd_addr_a,
  input  logic [ADDR_W-1:0] fwd_addr_b,
  output logic              fwd_hit_a,
  output logic [DATA_W-1:0] fwd_data_a,
  output logic              fwd_hit_b,
  output logic [DATA_W-1:0] fwd_data_b,
  output logic              wb_idle
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_STROBE} wb_state_e;

  wb_state_e               state, next_state;
  logic [CNT_W-1:0]        count;
  logic [DEPTH*ADDR_W-1:0] slot_addr;
  logic [DEPTH*DATA_W-1:0] slot_data;
  logic [DEPTH-1:0]        slot_valid;
  logic [DATA_W-1:0]       wb_value;
  logic                    push, pop;
  fwd_result_t             fwd_a, fwd_b;

  // Stall comes from the registered count only, so a same-cycle pop never releases it.
  assign wb_stall = (count == CNT_W'(DEPTH));
  assign push     = wb_valid & ~wb_stall & (wb_dest != REG_ZERO);
  assign pop      = (state == ST_STROBE);
  assign wb_value = wb_mux(wb_sel_e'(wb_sel), alu_result, mem_data, pc_link, imm);
  assign wb_idle  = (count == '0) && (state == ST_IDLE);

  wb_queue #(.DEPTH(DEPTH)) u_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_addr (wb_dest),
    .push_data (wb_value),
    .pop       (pop),
    .count     (count),
    .slot_addr (slot_addr),
    .slot_data (slot_data),
    .slot_valid(slot_valid)
  );

  // NOTE: all outputs of this block get a default first so no latch is inferred.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:   if (count != '0) next_state = ST_SETUP;
      ST_SETUP:  next_state = ST_STROBE;
      ST_STROBE: next_state = (count > CNT_W'(1)) ? ST_SETUP : ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
  end

  // Address/data load on entry to SETUP; leaving STROBE the old head is being popped, so load slot 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      rf_write   <= 1'b0;
      rf_address <= '0;
      rf_data_in <= '0;
    end else begin
      state    <= next_state;
      rf_write <= (next_state == ST_STROBE);
      if (next_state == ST_SETUP) begin
        if (state == ST_STROBE) begin
          rf_address <= slot_addr[ADDR_W +: ADDR_W];
          rf_data_in <= slot_data[DATA_W +: DATA_W];
        end else begin
          rf_address <= slot_addr[0 +: ADDR_W];
          rf_data_in <= slot_data[0 +: DATA_W];
        end
      end
    end
  end

  // Slots are scanned oldest to youngest so the youngest match wins.
  function automatic fwd_result_t fwd_lookup(input logic [ADDR_W-1:0]       addr,
                                             input logic [DEPTH*ADDR_W-1:0] a,
                                             input logic [DEPTH*DATA_W-1:0] d,
                                             input logic [DEPTH-1:0]        v);
    fwd_result_t r;
    r = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (v[i] && (addr != REG_ZERO) && (a[i*ADDR_W +: ADDR_W] == addr)) begin
        r.hit  = 1'b1;
        r.data = d[i*DATA_W +: DATA_W];
      end
    end
    return r;
  endfunction

  always_comb begin
    fwd_a = fwd_lookup(fwd_addr_a, slot_addr, slot_data, slot_valid);
    fwd_b = fwd_lookup(fwd_addr_b, slot_addr, slot_data, slot_valid);
  end

  assign fwd_hit_a  = fwd_a.hit;
  assign fwd_data_a = fwd_a.data;
  assign fwd_hit_b  = fwd_b.hit;
  assign fwd_data_b = fwd_b.data;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed and randomised checks of the writeback stage: timing of the
// SETUP/STROBE sequence, stall, forwarding, reset mid-strobe, final regfile.
module tb_writeback_stage;
  import cpu_defs::*;

  logic              clk, rst;
  logic              wb_valid;
  logic [ADDR_W-1:0] wb_dest;
  logic [1:0]        wb_sel;
  logic [DATA_W-1:0] alu_result, mem_data, pc_link, imm;
  logic              wb_stall, rf_write;
  logic [ADDR_W-1:0] rf_address;
  logic [DATA_W-1:0] rf_data_in;
  logic [ADDR_W-1:0] fwd_addr_a, fwd_addr_b;
  logic              fwd_hit_a, fwd_hit_b;
  logic [DATA_W-1:0] fwd_data_a, fwd_data_b;
  logic              wb_idle;

  writeback_stage #(.DEPTH(2)) dut (
    .clk(clk), .rst(rst), .wb_valid(wb_valid), .wb_dest(wb_dest), .wb_sel(wb_sel),
    .alu_result(alu_result), .mem_data(mem_data), .pc_link(pc_link), .imm(imm),
    .wb_stall(wb_stall), .rf_write(rf_write), .rf_address(rf_address), .rf_data_in(rf_data_in),
    .fwd_addr_a(fwd_addr_a), .fwd_addr_b(fwd_addr_b), .fwd_hit_a(fwd_hit_a),
    .fwd_data_a(fwd_data_a), .fwd_hit_b(fwd_hit_b), .fwd_data_b(fwd_data_b), .wb_idle(wb_idle)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Register-file side: captures every committed write from the strobe.
  logic [DATA_W-1:0] cap [16];
  logic [ADDR_W-1:0] log_addr [$];
  logic [DATA_W-1:0] log_data [$];
  logic              prev_write = 1'b0;
  int                pulses = 0;

  initial for (int r = 0; r < 16; r++) cap[r] = '0;

  always @(negedge clk) begin
    if (rf_write === 1'b1) begin
      check("no_back_to_back_strobe", 32'(prev_write), 32'd0);
      pulses++;
      cap[rf_address] = rf_data_in;
      log_addr.push_back(rf_address);
      log_data.push_back(rf_data_in);
    end
    prev_write = (rf_write === 1'b1);
  end

  task automatic send(input logic [ADDR_W-1:0] dest, input logic [1:0] sel,
                      input logic [DATA_W-1:0] val);
    logic acc;
    acc        = 1'b0;
    wb_valid   = 1'b1;
    wb_dest    = dest;
    wb_sel     = sel;
    alu_result = (sel == 2'd0) ? val : 16'hDEAD;
    mem_data   = (sel == 2'd1) ? val : 16'hDEAD;
    pc_link    = (sel == 2'd2) ? val : 16'hDEAD;
    imm        = (sel == 2'd3) ? val : 16'hDEAD;
    for (int n = 0; n < 20; n++) begin
      acc = (wb_stall === 1'b0);
      tick();
      if (acc) break;
    end
    wb_valid = 1'b0;
    check("send_accepted", 32'(acc), 32'd1);
  endtask

  task automatic wait_idle(input int budget);
    for (int n = 0; n < budget && wb_idle !== 1'b1; n++) tick();
    check("drain_to_idle", 32'(wb_idle), 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  typedef struct {
    logic [ADDR_W-1:0] dest;
    logic [1:0]        sel;
    logic [DATA_W-1:0] alu, mem, link, immv;
    logic [DATA_W-1:0] exp;
  } vec_t;

  vec_t              vecs [4];
  logic [DATA_W-1:0] model [16];
  int                base, p0;
  logic              acc;

  initial begin
    vecs[0] = '{4'd3,   2'd0, 16'h1234, 16'h5555, 16'h6666, 16'h7777, 16'h1234};
    vecs[1] = '{REG_IH, 2'd1, 16'h1111, 16'hA5A5, 16'h2222, 16'h3333, 16'hA5A5};
    vecs[2] = '{REG_T,  2'd2, 16'h0F0F, 16'h1010, 16'h0042, 16'h9999, 16'h0042};
    vecs[3] = '{REG_SP, 2'd3, 16'h0000, 16'h0001, 16'h0002, 16'hFFFE, 16'hFFFE};

    wb_valid = 0; wb_dest = 0; wb_sel = 0;
    alu_result = 0; mem_data = 0; pc_link = 0; imm = 0;
    fwd_addr_a = 4'd3; fwd_addr_b = 4'd3;
    rst = 1'b1;
    tick();
    tick();
    check("reset_rf_write",   32'(rf_write),   32'd0);
    check("reset_rf_address", 32'(rf_address), 32'd0);
    check("reset_rf_data_in", 32'(rf_data_in), 32'd0);
    check("reset_wb_stall",   32'(wb_stall),   32'd0);
    check("reset_fwd_hit_a",  32'(fwd_hit_a),  32'd0);
    check("reset_fwd_hit_b",  32'(fwd_hit_b),  32'd0);
    check("reset_wb_idle",    32'(wb_idle),    32'd1);
    rst = 1'b0;

    // Single accepts through each value-select path, cycle-exact timing.
    for (int v = 0; v < 4; v++) begin
      fwd_addr_a = vecs[v].dest;
      fwd_addr_b = vecs[v].dest;
      wb_valid = 1'b1; wb_dest = vecs[v].dest; wb_sel = vecs[v].sel;
      alu_result = vecs[v].alu; mem_data = vecs[v].mem;
      pc_link = vecs[v].link; imm = vecs[v].immv;
      tick();
      wb_valid = 1'b0;
      check("c1_rf_write",   32'(rf_write),   32'd0);
      check("c1_wb_idle",    32'(wb_idle),    32'd0);
      check("c1_fwd_hit_a",  32'(fwd_hit_a),  32'd1);
      check("c1_fwd_data_a", 32'(fwd_data_a), 32'(vecs[v].exp));
      check("c1_fwd_data_b", 32'(fwd_data_b), 32'(vecs[v].exp));
      tick();
      check("c2_rf_address", 32'(rf_address), 32'(vecs[v].dest));
      check("c2_rf_data_in", 32'(rf_data_in), 32'(vecs[v].exp));
      check("c2_rf_write",   32'(rf_write),   32'd0);
      tick();
      check("c3_rf_write",   32'(rf_write),   32'd1);
      check("c3_fwd_hit_a",  32'(fwd_hit_a),  32'd1);
      tick();
      check("c4_rf_write",   32'(rf_write),   32'd0);
      check("c4_wb_idle",    32'(wb_idle),    32'd1);
      check("c4_fwd_hit_a",  32'(fwd_hit_a),  32'd0);
      check("c4_committed",  32'(cap[vecs[v].dest]), 32'(vecs[v].exp));
    end

    // Back-to-back accepts fill the queue and stall.
    base = log_addr.size();
    send(4'd1, 2'd0, 16'h0001);
    send(4'd2, 2'd0, 16'h0002);
    check("b2b_stall_when_full", 32'(wb_stall), 32'd1);
    send(REG_SP, 2'd0, 16'hFFFE);
    wait_idle(40);
    check("b2b_pulse_count", 32'(log_addr.size() - base), 32'd3);
    if (log_addr.size() >= base + 3) begin
      check("b2b_order0", {12'd0, log_addr[base],   log_data[base]},   {12'd0, 4'd1,  16'h0001});
      check("b2b_order1", {12'd0, log_addr[base+1], log_data[base+1]}, {12'd0, 4'd2,  16'h0002});
      check("b2b_order2", {12'd0, log_addr[base+2], log_data[base+2]}, {12'd0, 4'd15, 16'hFFFE});
    end

    // Writes to R0 are dropped.
    p0 = pulses;
    fwd_addr_a = REG_ZERO;
    send(REG_ZERO, 2'd3, 16'hBEEF);
    check("r0_queue_empty", 32'(wb_idle),   32'd1);
    check("r0_no_fwd_hit",  32'(fwd_hit_a), 32'd0);
    for (int n = 0; n < 4; n++) tick();
    check("r0_no_strobe", 32'(pulses - p0), 32'd0);

    // Same destination twice: youngest forwarded until the second commit.
    fwd_addr_a = 4'd5;
    fwd_addr_b = 4'd6;
    send(4'd5, 2'd0, 16'h00AA);
    check("dup_fwd_first", 32'(fwd_data_a), 32'h00AA);
    send(4'd5, 2'd0, 16'h00BB);
    check("dup_fwd_b_miss", 32'(fwd_hit_b), 32'd0);
    acc = 1'b0;
    for (int n = 0; n < 20 && !acc; n++) begin
      check("dup_fwd_hit",   32'(fwd_hit_a),  32'd1);
      check("dup_fwd_young", 32'(fwd_data_a), 32'h00BB);
      acc = (rf_write === 1'b1) && (rf_data_in === 16'h00BB);
      tick();
    end
    check("dup_second_commit_seen", 32'(acc), 32'd1);
    check("dup_fwd_cleared", 32'(fwd_hit_a), 32'd0);
    check("dup_regfile_r5",  32'(cap[5]),    32'h00BB);

    // Reset during the first strobe with a second entry pending.
    send(4'd7, 2'd1, 16'h7777);
    send(4'd8, 2'd2, 16'h8888);
    acc = 1'b0;
    for (int n = 0; n < 10 && !acc; n++) begin
      acc = (rf_write === 1'b1);
      if (!acc) tick();
    end
    check("rst_strobe_reached", 32'(acc), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_rf_write",   32'(rf_write),   32'd0);
    check("rst_rf_address", 32'(rf_address), 32'd0);
    check("rst_rf_data_in", 32'(rf_data_in), 32'd0);
    check("rst_wb_idle",    32'(wb_idle),    32'd1);
    p0 = pulses;
    for (int n = 0; n < 6; n++) tick();
    check("rst_no_more_strobes", 32'(pulses - p0), 32'd0);
    check("rst_r7_committed",    32'(cap[7]),       32'h7777);
    check("rst_r8_discarded",    32'(cap[8]),       32'h0000);

    // Randomised stream against a reference register file.
    do_reset();
    for (int r = 0; r < 16; r++) begin
      model[r] = '0;
      cap[r]   = '0;
    end
    wb_valid = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (!(wb_valid && wb_stall)) begin
        wb_valid   = 1'($urandom_range(0, 1));
        wb_dest    = 4'($urandom_range(0, 15));
        wb_sel     = 2'($urandom_range(0, 3));
        alu_result = 16'($urandom);
        mem_data   = 16'($urandom);
        pc_link    = 16'($urandom);
        imm        = 16'($urandom);
      end
      if (wb_valid && !wb_stall && wb_dest != 4'd0) begin
        case (wb_sel)
          2'd0: model[wb_dest] = alu_result;
          2'd1: model[wb_dest] = mem_data;
          2'd2: model[wb_dest] = pc_link;
          default: model[wb_dest] = imm;
        endcase
      end
      tick();
    end
    wb_valid = 1'b0;
    wait_idle(40);
    for (int r = 0; r < 16; r++) check($sformatf("rand_reg_%0d", r), 32'(cap[r]), 32'(model[r]));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
